// File: rtl/arashi_host.sv
// arashi_host: one request FSM per thread, turning valid/ready requests into arashi_top ctrl/data_in traffic.
// Optional write-wait timeout is built when ARASHI_HOST_TIMEOUT_EN is defined.
module arashi_host #(
  parameter int DATA_WIDTH       = 32,
  parameter int THREAD_NUM_WIDTH = 2,
  parameter int RD_LATENCY       = 2,
  parameter int TIMEOUT          = 255,
  localparam int THREAD_NUM      = 1 << THREAD_NUM_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [THREAD_NUM-1:0]            req_valid,
  output logic [THREAD_NUM-1:0]            req_ready,
  input  logic [THREAD_NUM-1:0]            req_wr,
  input  logic [DATA_WIDTH*THREAD_NUM-1:0] req_data,
  output logic [THREAD_NUM-1:0]            rsp_valid,
  input  logic [THREAD_NUM-1:0]            rsp_ready,
  output logic [DATA_WIDTH*THREAD_NUM-1:0] rsp_data,
  output logic [THREAD_NUM-1:0]            rsp_err,
  output logic [THREAD_NUM*2-1:0]          ctrl,
  output logic [DATA_WIDTH*THREAD_NUM-1:0] data_in,
  input  logic [THREAD_NUM-1:0]            w_ready,
  input  logic [DATA_WIDTH*THREAD_NUM-1:0] data_out
);

  if (THREAD_NUM_WIDTH < 2 || THREAD_NUM_WIDTH > 4) begin : g_bad_thread_width
    $error("arashi_host: THREAD_NUM_WIDTH must be within 2..4");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 15) begin : g_bad_rd_latency
    $error("arashi_host: RD_LATENCY must be within 1..15");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("arashi_host: TIMEOUT must be within 1..65535");
  end

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_W_WAIT  = 3'd1,
    ST_R_ISSUE = 3'd2,
    ST_R_WAIT  = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  for (genvar t = 0; t < THREAD_NUM; t++) begin : g_thread
    state_t                state_r;
    state_t                state_s;
    logic [3:0]            lat_r;
    logic [1:0]            ctrl_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic                  wr_exit_s;

`ifdef ARASHI_HOST_TIMEOUT_EN
    logic [15:0] wait_r;
    logic        timeout_s;
    logic        err_r;

    // w_ready wins over the limit, so a write arriving on the last cycle completes cleanly
    assign timeout_s = (state_r == ST_W_WAIT) && (wait_r == 16'(TIMEOUT - 1));
    assign wr_exit_s = w_ready[t] | timeout_s;

    // write-wait counter, cleared whenever the thread is outside W_WAIT
    always_ff @(posedge clk) begin
      if (rst) begin
        wait_r <= 16'd0;
      end else if (state_r != ST_W_WAIT) begin
        wait_r <= 16'd0;
      end else if (!w_ready[t]) begin
        wait_r <= wait_r + 16'd1;
      end
    end

    // error flag captured when leaving W_WAIT
    always_ff @(posedge clk) begin
      if (rst) begin
        err_r <= 1'b0;
      end else if (state_r == ST_W_WAIT && wr_exit_s) begin
        err_r <= ~w_ready[t];
      end
    end

    assign rsp_err[t] = err_r;
`else
    assign wr_exit_s  = w_ready[t];
    assign rsp_err[t] = 1'b0;
`endif

    // next-state logic
    always_comb begin
      state_s = state_r;
      case (state_r)
        ST_IDLE: begin
          if (req_valid[t]) begin
            state_s = req_wr[t] ? ST_W_WAIT : ST_R_ISSUE;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_W_WAIT: begin
          if (wr_exit_s) begin
            state_s = ST_RESP;
          end else begin
            state_s = ST_W_WAIT;
          end
        end
        ST_R_ISSUE: begin
          state_s = ST_R_WAIT;
        end
        ST_R_WAIT: begin
          if (lat_r == 4'd0) begin
            state_s = ST_RESP;
          end else begin
            state_s = ST_R_WAIT;
          end
        end
        ST_RESP: begin
          if (rsp_ready[t]) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_RESP;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end

    // state register
    always_ff @(posedge clk) begin
      if (rst) begin
        state_r <= ST_IDLE;
      end else begin
        state_r <= state_s;
      end
    end

    // ctrl is decoded from the next state so it lines up with the state register
    always_ff @(posedge clk) begin
      if (rst) begin
        ctrl_r <= 2'b00;
      end else begin
        case (state_s)
          ST_W_WAIT:  ctrl_r <= 2'b10;
          ST_R_ISSUE: ctrl_r <= 2'b01;
          default:    ctrl_r <= 2'b00;
        endcase
      end
    end

    // write-data latch, read-latency counter and response data capture
    always_ff @(posedge clk) begin
      if (rst) begin
        wdata_r <= '0;
        rdata_r <= '0;
        lat_r   <= 4'd0;
      end else begin
        if (state_r == ST_IDLE && req_valid[t] && req_wr[t]) begin
          wdata_r <= req_data[t*DATA_WIDTH +: DATA_WIDTH];
        end
        if (state_r == ST_R_ISSUE) begin
          lat_r <= 4'(RD_LATENCY - 1);
        end else if (state_r == ST_R_WAIT && lat_r != 4'd0) begin
          lat_r <= lat_r - 4'd1;
        end
        if (state_r == ST_R_WAIT && lat_r == 4'd0) begin
          rdata_r <= data_out[t*DATA_WIDTH +: DATA_WIDTH];
        end else if (state_r == ST_W_WAIT && wr_exit_s) begin
          rdata_r <= '0;
        end
      end
    end

    assign req_ready[t]                           = (state_r == ST_IDLE) & ~rst;
    assign rsp_valid[t]                           = (state_r == ST_RESP);
    assign rsp_data[t*DATA_WIDTH +: DATA_WIDTH]   = rdata_r;
    assign data_in[t*DATA_WIDTH +: DATA_WIDTH]    = wdata_r;
    assign ctrl[2*t +: 2]                         = ctrl_r;
  end

endmodule

// File: tb/tb_arashi_host.sv
// tb_arashi_host: random and directed stimulus for arashi_host, checked every cycle against a
// transaction-timeline model (accept cycle, response cycle, captured data) kept in the bench.
module tb_arashi_host;
  localparam int DW  = 32;
  localparam int TNW = 2;
  localparam int TN  = 4;
  localparam int RDL = 2;
  localparam int TO  = 8;

  logic            clk;
  logic            rst;
  logic [TN-1:0]   req_valid;
  logic [TN-1:0]   req_ready;
  logic [TN-1:0]   req_wr;
  logic [DW*TN-1:0] req_data;
  logic [TN-1:0]   rsp_valid;
  logic [TN-1:0]   rsp_ready;
  logic [DW*TN-1:0] rsp_data;
  logic [TN-1:0]   rsp_err;
  logic [TN*2-1:0] ctrl;
  logic [DW*TN-1:0] data_in;
  logic [TN-1:0]   w_ready;
  logic [DW*TN-1:0] data_out;

  arashi_host #(
    .DATA_WIDTH(DW), .THREAD_NUM_WIDTH(TNW), .RD_LATENCY(RDL), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .ctrl(ctrl), .data_in(data_in), .w_ready(w_ready), .data_out(data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Model: per thread, an outstanding transaction described by its accept cycle and response cycle.
  bit              busy_m [TN];
  bit              wr_m   [TN];
  bit              err_m  [TN];
  logic [DW-1:0]   wdata_m[TN];
  logic [DW-1:0]   rdata_m[TN];
  int              t_acc_m[TN];
  int              t_rsp_m[TN];
  int              cyc = 0;

  task automatic model_update();
    for (int i = 0; i < TN; i++) begin
      if (rst) begin
        busy_m[i]  = 1'b0;
        wdata_m[i] = '0;
      end else if (busy_m[i]) begin
        if (wr_m[i] && t_rsp_m[i] < 0) begin
          if (w_ready[i]) begin
            t_rsp_m[i] = cyc + 1;
            err_m[i]   = 1'b0;
          end
`ifdef ARASHI_HOST_TIMEOUT_EN
          else if (cyc - t_acc_m[i] == TO) begin
            t_rsp_m[i] = cyc + 1;
            err_m[i]   = 1'b1;
          end
`endif
        end
        if (!wr_m[i] && cyc == t_acc_m[i] + 1 + RDL) rdata_m[i] = data_out[i*DW +: DW];
        if (t_rsp_m[i] >= 0 && cyc >= t_rsp_m[i] && rsp_ready[i]) busy_m[i] = 1'b0;
      end else if (req_valid[i]) begin
        busy_m[i]  = 1'b1;
        t_acc_m[i] = cyc;
        wr_m[i]    = req_wr[i];
        err_m[i]   = 1'b0;
        if (req_wr[i]) begin
          wdata_m[i] = req_data[i*DW +: DW];
          t_rsp_m[i] = -1;
        end else begin
          t_rsp_m[i] = cyc + 2 + RDL;
        end
      end
    end
    cyc++;
  endtask

  task automatic compare_all();
    for (int i = 0; i < TN; i++) begin
      logic       rv;
      logic [1:0] ec;
      rv = busy_m[i] && (t_rsp_m[i] >= 0) && (cyc >= t_rsp_m[i]);
      if (!busy_m[i])    ec = 2'b00;
      else if (wr_m[i])  ec = (t_rsp_m[i] < 0) ? 2'b10 : 2'b00;
      else               ec = (cyc == t_acc_m[i] + 1) ? 2'b01 : 2'b00;
      chk($sformatf("ctrl[%0d]", i), 128'(ctrl[2*i +: 2]), 128'(ec));
      chk($sformatf("req_ready[%0d]", i), 128'(req_ready[i]), 128'(!rst && !busy_m[i]));
      chk($sformatf("rsp_valid[%0d]", i), 128'(rsp_valid[i]), 128'(rv));
      chk($sformatf("data_in[%0d]", i), 128'(data_in[i*DW +: DW]), 128'(wdata_m[i]));
      if (rv) begin
        chk($sformatf("rsp_data[%0d]", i), 128'(rsp_data[i*DW +: DW]),
            wr_m[i] ? 128'd0 : 128'(rdata_m[i]));
        chk($sformatf("rsp_err[%0d]", i), 128'(rsp_err[i]), 128'(err_m[i]));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < TN; i++) begin
      busy_m[i] = 1'b0; wr_m[i] = 1'b0; err_m[i] = 1'b0;
      wdata_m[i] = '0; rdata_m[i] = '0; t_acc_m[i] = 0; t_rsp_m[i] = -1;
    end
    forever begin
      @(posedge clk);
      model_update();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      compare_all();
    end
  end

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic rand_inputs(input logic [TN-1:0] vmask);
    req_valid = 4'($urandom) & vmask;
    req_wr    = 4'($urandom);
    w_ready   = 4'($urandom);
    rsp_ready = 4'($urandom);
    for (int i = 0; i < TN; i++) begin
      req_data[i*DW +: DW] = $urandom;
      data_out[i*DW +: DW] = $urandom;
    end
  endtask

  task automatic rand_data_out();
    for (int i = 0; i < TN; i++) data_out[i*DW +: DW] = $urandom;
  endtask

  initial begin
    int k;
    int cnt;
    rst = 1'b1; req_valid = '0; req_wr = '0; req_data = '0;
    rsp_ready = '0; w_ready = '0; data_out = '0;

    // reset with random inputs
    for (int r = 0; r < 3; r++) begin
      next_cycle();
      chk("reset_ctrl", 128'(ctrl), 128'd0);
      chk("reset_req_ready", 128'(req_ready), 128'd0);
      chk("reset_rsp_valid", 128'(rsp_valid), 128'd0);
      rand_inputs(4'hF);
    end
    next_cycle();
    rst = 1'b0; req_valid = '0; rsp_ready = '0; w_ready = '0;
    next_cycle();
    chk("post_reset_req_ready", 128'(req_ready), 128'(4'b1111));

    // write on thread 0; w_ready during the accept cycle must be ignored
    req_valid = 4'b0001; req_wr = 4'b0001; req_data[31:0] = 32'hDEADBEEF; w_ready = 4'b0001;
    next_cycle();
    req_valid = '0; w_ready = '0;
    chk("wr_ctrl_a1", 128'(ctrl[1:0]), 128'(2'b10));
    chk("wr_data_in", 128'(data_in[31:0]), 128'(32'hDEADBEEF));
    next_cycle();
    chk("wr_ctrl_a2", 128'(ctrl[1:0]), 128'(2'b10));
    next_cycle();
    chk("wr_ctrl_a3", 128'(ctrl[1:0]), 128'(2'b10));
    w_ready = 4'b0001;
    next_cycle();
    w_ready = '0;
    chk("wr_ctrl_done", 128'(ctrl[1:0]), 128'(2'b00));
    chk("wr_rsp_valid", 128'(rsp_valid[0]), 128'd1);
    chk("wr_rsp_err", 128'(rsp_err[0]), 128'd0);
    chk("wr_rsp_data", 128'(rsp_data[31:0]), 128'd0);
    rsp_ready = 4'b0001;
    next_cycle();
    rsp_ready = '0;
    chk("wr_rsp_drop", 128'(rsp_valid[0]), 128'd0);
    chk("wr_idle_ready", 128'(req_ready[0]), 128'd1);
    chk("wr_data_held", 128'(data_in[31:0]), 128'(32'hDEADBEEF));

    // read on thread 2, data valid two cycles after ctrl=01
    req_valid = 4'b0100; req_wr = 4'b0000; rand_data_out();
    next_cycle();
    req_valid = '0; rand_data_out();
    chk("rd_ctrl_issue", 128'(ctrl[5:4]), 128'(2'b01));
    next_cycle();
    rand_data_out();
    chk("rd_ctrl_after", 128'(ctrl[5:4]), 128'(2'b00));
    next_cycle();
    data_out[95:64] = 32'h12345678;
    next_cycle();
    rand_data_out();
    chk("rd_rsp_valid", 128'(rsp_valid[2]), 128'd1);
    chk("rd_rsp_data", 128'(rsp_data[95:64]), 128'(32'h12345678));
    rsp_ready = 4'b0100;
    next_cycle();
    rsp_ready = '0;
    chk("rd_rsp_drop", 128'(rsp_valid[2]), 128'd0);

    // all threads at once: 0/1 write, 2/3 read, random completion order
    rand_inputs(4'h0);
    req_valid = 4'b1111; req_wr = 4'b0011; w_ready = '0; rsp_ready = '0;
    k = 0;
    do begin
      next_cycle();
      rand_inputs(4'h0);
      k++;
    end while (req_ready != 4'hF && k < 200);
    chk("concurrent_all_done", 128'(req_ready), 128'(4'hF));

    // backpressure on thread 1 while the others run random traffic
    rand_inputs(4'b1101);
    req_valid[1] = 1'b1; req_wr[1] = 1'b0; rsp_ready[1] = 1'b0;
    k = 0;
    do begin
      next_cycle();
      rand_inputs(4'b1101);
      rsp_ready[1] = 1'b0;
      k++;
    end while (!rsp_valid[1] && k < 20);
    chk("bp_rsp_seen", 128'(rsp_valid[1]), 128'd1);
    for (int b = 0; b < 10; b++) begin
      next_cycle();
      rand_inputs(4'b1101);
      rsp_ready[1] = 1'b0;
      chk("bp_valid_held", 128'(rsp_valid[1]), 128'd1);
      chk("bp_data_held", 128'(rsp_data[63:32]), 128'(rdata_m[1]));
      chk("bp_req_ready", 128'(req_ready[1]), 128'd0);
    end
    rsp_ready[1] = 1'b1;
    req_valid = '0;
    next_cycle();
    chk("bp_released", 128'(rsp_valid[1]), 128'd0);

    // drain everything before the timeout test
    k = 0;
    do begin
      req_valid = '0; w_ready = 4'hF; rsp_ready = 4'hF;
      next_cycle();
      k++;
    end while (req_ready != 4'hF && k < 100);
    chk("drain_idle", 128'(req_ready), 128'(4'hF));

    // write on thread 3 with w_ready never asserted
    w_ready = '0; rsp_ready = '0;
    req_valid = 4'b1000; req_wr = 4'b1000; req_data[127:96] = $urandom;
`ifdef ARASHI_HOST_TIMEOUT_EN
    k = 0;
    do begin
      next_cycle();
      req_valid = '0;
      k++;
    end while (!rsp_valid[3] && k < 50);
    chk("timeout_latency", 128'(k), 128'(TO + 1));
    chk("timeout_err", 128'(rsp_err[3]), 128'd1);
    chk("timeout_ctrl", 128'(ctrl[7:6]), 128'(2'b00));
    rsp_ready = 4'b1000;
    next_cycle();
    rsp_ready = '0;
`else
    cnt = 0;
    for (int w = 0; w < 120; w++) begin
      next_cycle();
      req_valid = '0;
      if (ctrl[7:6] == 2'b10 && !rsp_valid[3]) cnt++;
    end
    chk("no_timeout_wait", 128'(cnt), 128'd120);
    w_ready = 4'b1000;
    next_cycle();
    w_ready = '0;
    chk("late_wready_rsp", 128'(rsp_valid[3]), 128'd1);
    rsp_ready = 4'b1000;
    next_cycle();
    rsp_ready = '0;
`endif

    // random traffic with occasional resets
    for (int n = 0; n < 1500; n++) begin
      next_cycle();
      rand_inputs(4'hF);
      rst = ($urandom_range(0, 299) == 0);
    end
    next_cycle();
    rst = 1'b0; req_valid = '0;
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
